// File: rtl/ram_port_arb_pkg.sv
// ram_port_arb_pkg: shared types and constants for the HyperRAM host-port arbiter.
//   arb_state_t   : FSM encoding (IDLE, ISSUE, XFER)
//   BURST_LEN_DEF : default halfword beats per burst
//   PORT_IF/PORT_D: port indices (instruction fetch, data)
package ram_port_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        XFER  = 2'd2
    } arb_state_t;

    localparam int   BURST_LEN_DEF = 8;
    localparam logic PORT_IF       = 1'b0;
    localparam logic PORT_D        = 1'b1;

endpackage

// File: rtl/ram_arb_rr.sv
// ram_arb_rr: combinational 2-way round-robin picker.
//   req[1:0] in  : pending requests
//   last     in  : port granted most recently
//   valid    out : at least one request pending
//   winner   out : selected port (on a tie, the port that is not last)
module ram_arb_rr (
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       winner
);

    assign valid  = |req;
    assign winner = &req ? ~last : req[1];

endmodule

// File: rtl/ram_port_arb.sv
// ram_port_arb: round-robin share of the HyperRAM core host port between
// instruction fetch (port 0) and data (port 1), with a stall watchdog.
//   pN_req/rwn/burst/addr in, pN_ack out        : request channel per port
//   pN_txm/txd in, pN_txd_ack out               : write beats per port
//   pN_rxd/rxd_vld out                          : read beats per port
//   host_req/rwn/burst/addr out, host_ack in    : request channel to core
//   host_txm/txd out, host_txd_ack in           : write beats to core
//   host_rxd/rxd_vld in                         : read beats from core
//   busy out, err out (sticky), err_clr in      : status
module ram_port_arb
    import ram_port_arb_pkg::*;
#(
    parameter int BURST_LEN = BURST_LEN_DEF,
    parameter int TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic        p0_rwn,
    input  logic        p0_burst,
    input  logic [31:0] p0_addr,
    output logic        p0_ack,
    input  logic [1:0]  p0_txm,
    input  logic [15:0] p0_txd,
    output logic        p0_txd_ack,
    output logic [15:0] p0_rxd,
    output logic        p0_rxd_vld,
    input  logic        p1_req,
    input  logic        p1_rwn,
    input  logic        p1_burst,
    input  logic [31:0] p1_addr,
    output logic        p1_ack,
    input  logic [1:0]  p1_txm,
    input  logic [15:0] p1_txd,
    output logic        p1_txd_ack,
    output logic [15:0] p1_rxd,
    output logic        p1_rxd_vld,
    output logic        host_req,
    output logic        host_rwn,
    output logic        host_burst,
    output logic [31:0] host_addr,
    input  logic        host_ack,
    output logic [1:0]  host_txm,
    output logic [15:0] host_txd,
    input  logic        host_txd_ack,
    input  logic [15:0] host_rxd,
    input  logic        host_rxd_vld,
    output logic        busy,
    output logic        err,
    input  logic        err_clr
);

    localparam int BW = $clog2(BURST_LEN) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    arb_state_t    state, state_nxt;
    logic          rwn_q, burst_q, gnt, last;
    logic [31:0]   addr_q;
    logic [BW-1:0] beats, beats_nxt;
    logic [TW-1:0] timer;
    logic          valid, winner, beat, done, abort, g0, g1;

    ram_arb_rr u_rr (
        .req    ({p1_req, p0_req}),
        .last   (last),
        .valid  (valid),
        .winner (winner)
    );

    assign busy      = state != IDLE;
    assign g0        = busy & (gnt == PORT_IF);
    assign g1        = busy & (gnt == PORT_D);
    // Beats only count while a transaction is live, so stragglers after an abort vanish.
    assign beat      = busy & (rwn_q ? host_rxd_vld : host_txd_ack);
    assign beats_nxt = (beat && beats != '0) ? beats - 1'b1 : beats;
    // Completion is judged after this cycle's beat; it takes priority over the watchdog.
    assign done      = (state == XFER || (state == ISSUE && host_ack)) && beats_nxt == '0;
    assign abort     = busy && timer == TW'(TIMEOUT) && !done;

    always_comb begin
        state_nxt = state;
        state_nxt = state == IDLE ? (valid ? ISSUE : IDLE) :
                    (done || abort) ? IDLE :
                    (state == ISSUE && host_ack) ? XFER : state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rwn_q   <= 1'b1;
            burst_q <= 1'b0;
            addr_q  <= '0;
            gnt     <= PORT_IF;
            last    <= PORT_D;
            beats   <= '0;
            timer   <= '0;
            err     <= 1'b0;
        end else begin
            state <= state_nxt;
            err   <= abort | (err & ~err_clr);
            if (state == IDLE) begin
                if (valid) begin
                    rwn_q   <= winner ? p1_rwn : p0_rwn;
                    burst_q <= winner ? p1_burst : p0_burst;
                    addr_q  <= winner ? p1_addr : p0_addr;
                    gnt     <= winner;
                    last    <= winner;
                    beats   <= (winner ? p1_burst : p0_burst) ? BW'(BURST_LEN) : BW'(1);
                    timer   <= '0;
                end
            end else begin
                beats <= beats_nxt;
                if (!(&timer))
                    timer <= timer + 1'b1;
            end
        end
    end

    assign host_req   = state == ISSUE;
    assign host_rwn   = rwn_q;
    assign host_burst = burst_q;
    assign host_addr  = addr_q;
    assign p0_ack     = host_req & host_ack & (gnt == PORT_IF);
    assign p1_ack     = host_req & host_ack & (gnt == PORT_D);
    assign host_txd   = g1 ? p1_txd : g0 ? p0_txd : '0;
    assign host_txm   = g1 ? p1_txm : g0 ? p0_txm : '0;
    assign p0_txd_ack = g0 & host_txd_ack;
    assign p1_txd_ack = g1 & host_txd_ack;
    assign p0_rxd     = busy ? host_rxd : '0;
    assign p1_rxd     = busy ? host_rxd : '0;
    assign p0_rxd_vld = g0 & host_rxd_vld;
    assign p1_rxd_vld = g1 & host_rxd_vld;

endmodule

// File: tb/tb_ram_port_arb.sv
// tb_ram_port_arb: directed self-checking bench for ram_port_arb.
module tb_ram_port_arb;

    logic        clk = 0, rst = 1;
    logic        p0_req = 0, p0_rwn = 1, p0_burst = 0;
    logic [31:0] p0_addr = 0;
    logic [1:0]  p0_txm = 0;
    logic [15:0] p0_txd = 0;
    logic        p1_req = 0, p1_rwn = 1, p1_burst = 0;
    logic [31:0] p1_addr = 0;
    logic [1:0]  p1_txm = 0;
    logic [15:0] p1_txd = 0;
    logic        host_ack = 0, host_txd_ack = 0, host_rxd_vld = 0, err_clr = 0;
    logic [15:0] host_rxd = 0;
    logic        p0_ack, p0_txd_ack, p0_rxd_vld, p1_ack, p1_txd_ack, p1_rxd_vld;
    logic [15:0] p0_rxd, p1_rxd, host_txd;
    logic [1:0]  host_txm;
    logic        host_req, host_rwn, host_burst, busy, err;
    logic [31:0] host_addr;
    int          n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    ram_port_arb dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_rwn(p0_rwn), .p0_burst(p0_burst), .p0_addr(p0_addr),
        .p0_ack(p0_ack), .p0_txm(p0_txm), .p0_txd(p0_txd), .p0_txd_ack(p0_txd_ack),
        .p0_rxd(p0_rxd), .p0_rxd_vld(p0_rxd_vld),
        .p1_req(p1_req), .p1_rwn(p1_rwn), .p1_burst(p1_burst), .p1_addr(p1_addr),
        .p1_ack(p1_ack), .p1_txm(p1_txm), .p1_txd(p1_txd), .p1_txd_ack(p1_txd_ack),
        .p1_rxd(p1_rxd), .p1_rxd_vld(p1_rxd_vld),
        .host_req(host_req), .host_rwn(host_rwn), .host_burst(host_burst),
        .host_addr(host_addr), .host_ack(host_ack), .host_txm(host_txm),
        .host_txd(host_txd), .host_txd_ack(host_txd_ack), .host_rxd(host_rxd),
        .host_rxd_vld(host_rxd_vld), .busy(busy), .err(err), .err_clr(err_clr)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        tick;
        tick;
        #1;
        n_checks++;
        if ({host_req, host_rwn, host_burst, busy, err} !== 5'b01000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 01000", {host_req, host_rwn, host_burst, busy, err});
        end
        n_checks++;
        if (host_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_addr: got %h want 0", host_addr);
        end
        n_checks++;
        if ({p0_ack, p1_ack, p0_txd_ack, p1_txd_ack, p0_rxd_vld, p1_rxd_vld} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_port_strobes: got %b want 000000",
                     {p0_ack, p1_ack, p0_txd_ack, p1_txd_ack, p0_rxd_vld, p1_rxd_vld});
        end
        rst = 0;
        tick;
    endtask

    task automatic test_single_read;
        p0_req = 1; p0_rwn = 1; p0_burst = 0; p0_addr = 32'h100;
        tick;
        n_checks++;
        if ({host_req, host_rwn, host_burst, host_addr} !== {3'b110, 32'h100}) begin
            n_fail++;
            $display("FAIL sr_issue: got req=%b rwn=%b burst=%b addr=%h want 1 1 0 00000100",
                     host_req, host_rwn, host_burst, host_addr);
        end
        tick;
        n_checks++;
        if (p0_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL sr_early_ack: got %b want 0", p0_ack);
        end
        host_ack = 1;
        #1;
        n_checks++;
        if ({p0_ack, p1_ack} !== 2'b10) begin
            n_fail++;
            $display("FAIL sr_ack: got p0=%b p1=%b want 1 0", p0_ack, p1_ack);
        end
        tick;
        host_ack = 0; p0_req = 0;
        host_rxd_vld = 1; host_rxd = 16'hBEEF;
        #1;
        n_checks++;
        if ({p0_rxd_vld, p1_rxd_vld, p0_rxd, busy} !== {2'b10, 16'hBEEF, 1'b1}) begin
            n_fail++;
            $display("FAIL sr_data: got vld0=%b vld1=%b rxd=%h busy=%b want 1 0 beef 1",
                     p0_rxd_vld, p1_rxd_vld, p0_rxd, busy);
        end
        tick;
        host_rxd_vld = 0;
        #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL sr_idle: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_burst_write;
        int acks = 0;
        p1_req = 1; p1_rwn = 0; p1_burst = 1; p1_addr = 32'h200;
        tick;
        n_checks++;
        if ({host_req, host_rwn, host_burst, host_addr} !== {3'b101, 32'h200}) begin
            n_fail++;
            $display("FAIL bw_issue: got req=%b rwn=%b burst=%b addr=%h want 1 0 1 00000200",
                     host_req, host_rwn, host_burst, host_addr);
        end
        host_ack = 1;
        #1;
        n_checks++;
        if ({p0_ack, p1_ack} !== 2'b01) begin
            n_fail++;
            $display("FAIL bw_ack: got p0=%b p1=%b want 0 1", p0_ack, p1_ack);
        end
        tick;
        host_ack = 0; p1_req = 0;
        for (int i = 0; i < 8; i++) begin
            p1_txd = 16'(i); p1_txm = 2'b11; p0_txd = 16'hDEAD; host_txd_ack = 1;
            #1;
            n_checks++;
            if ({host_txd, host_txm, p0_txd_ack} !== {16'(i), 2'b11, 1'b0}) begin
                n_fail++;
                $display("FAIL bw_beat%0d: got txd=%h txm=%b p0_txd_ack=%b want %h 11 0",
                         i, host_txd, host_txm, p0_txd_ack, 16'(i));
            end
            if (p1_txd_ack === 1'b1) acks++;
            tick;
        end
        host_txd_ack = 0;
        n_checks++;
        if (acks !== 8 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bw_done: got acks=%0d busy=%b want 8 0", acks, busy);
        end
    endtask

    task automatic test_alternate;
        logic exp_g;
        p0_req = 1; p0_rwn = 1; p0_burst = 0; p0_addr = 32'h10;
        p1_req = 1; p1_rwn = 1; p1_burst = 0; p1_addr = 32'h20;
        exp_g = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int n = 0; n < 5 && !host_req; n++) tick;
            n_checks++;
            if (host_req !== 1'b1 || host_addr !== (exp_g ? 32'h20 : 32'h10)) begin
                n_fail++;
                $display("FAIL alt_grant%0d: got req=%b addr=%h want 1 %h",
                         k, host_req, host_addr, exp_g ? 32'h20 : 32'h10);
            end
            host_ack = 1; host_rxd_vld = 1; host_rxd = 16'(k);
            #1;
            n_checks++;
            if ({p0_ack, p1_ack, p0_rxd_vld, p1_rxd_vld} !== {~exp_g, exp_g, ~exp_g, exp_g}) begin
                n_fail++;
                $display("FAIL alt_route%0d: got %b want %b", k,
                         {p0_ack, p1_ack, p0_rxd_vld, p1_rxd_vld}, {~exp_g, exp_g, ~exp_g, exp_g});
            end
            tick;
            host_ack = 0; host_rxd_vld = 0;
            exp_g = ~exp_g;
        end
        p0_req = 0; p1_req = 0;
        tick;
    endtask

    task automatic test_watchdog;
        p0_req = 1; p0_rwn = 1; p0_burst = 0; p0_addr = 32'h300;
        tick;
        host_ack = 1;
        tick;
        host_ack = 0; p0_req = 0;
        for (int i = 0; i < 254; i++) tick;
        n_checks++;
        if ({busy, err} !== 2'b10) begin
            n_fail++;
            $display("FAIL wd_before: got busy=%b err=%b want 1 0", busy, err);
        end
        tick;
        n_checks++;
        if ({busy, err, host_req} !== 3'b010) begin
            n_fail++;
            $display("FAIL wd_abort: got busy=%b err=%b host_req=%b want 0 1 0", busy, err, host_req);
        end
        host_rxd_vld = 1;
        #1;
        n_checks++;
        if ({p0_rxd_vld, p1_rxd_vld} !== 2'b00) begin
            n_fail++;
            $display("FAIL wd_stray: got %b want 00", {p0_rxd_vld, p1_rxd_vld});
        end
        tick;
        host_rxd_vld = 0;
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL wd_sticky: got err=%b want 1", err);
        end
        err_clr = 1;
        tick;
        err_clr = 0;
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_clear: got err=%b want 0", err);
        end
    endtask

    task automatic test_last_beat_timeout;
        p1_req = 1; p1_rwn = 1; p1_burst = 0; p1_addr = 32'h400;
        tick;
        host_ack = 1;
        tick;
        host_ack = 0; p1_req = 0;
        for (int i = 0; i < 254; i++) tick;
        host_rxd_vld = 1; host_rxd = 16'h1234;
        #1;
        n_checks++;
        if (p1_rxd_vld !== 1'b1 || p1_rxd !== 16'h1234) begin
            n_fail++;
            $display("FAIL lt_beat: got vld=%b rxd=%h want 1 1234", p1_rxd_vld, p1_rxd);
        end
        tick;
        host_rxd_vld = 0;
        n_checks++;
        if ({busy, err} !== 2'b00) begin
            n_fail++;
            $display("FAIL lt_noerr: got busy=%b err=%b want 0 0", busy, err);
        end
    endtask

    task automatic test_reset_mid;
        p0_req = 1; p0_rwn = 0; p0_burst = 1; p0_addr = 32'h500;
        tick;
        host_ack = 1;
        tick;
        host_ack = 0; p0_req = 0;
        for (int i = 0; i < 3; i++) begin
            p0_txd = 16'(i); host_txd_ack = 1;
            tick;
        end
        rst = 1;
        #1;
        n_checks++;
        if ({busy, host_req, host_rwn, host_burst, err, p0_txd_ack} !== 6'b001000 || host_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL rm_async: got busy=%b req=%b rwn=%b burst=%b err=%b txd_ack=%b addr=%h want 0 0 1 0 0 0 0",
                     busy, host_req, host_rwn, host_burst, err, p0_txd_ack, host_addr);
        end
        tick;
        rst = 0; host_txd_ack = 0;
        p0_req = 1; p0_rwn = 1; p0_burst = 0; p0_addr = 32'h600;
        p1_req = 1; p1_rwn = 1; p1_burst = 0; p1_addr = 32'h700;
        tick;
        n_checks++;
        if (host_req !== 1'b1 || host_addr !== 32'h600) begin
            n_fail++;
            $display("FAIL rm_first: got req=%b addr=%h want 1 00000600", host_req, host_addr);
        end
        host_ack = 1; host_rxd_vld = 1;
        #1;
        n_checks++;
        if ({p0_ack, p1_ack} !== 2'b10) begin
            n_fail++;
            $display("FAIL rm_ack: got p0=%b p1=%b want 1 0", p0_ack, p1_ack);
        end
        tick;
        host_ack = 0; host_rxd_vld = 0; p0_req = 0; p1_req = 0;
        tick;
        tick;
    endtask

    initial begin
        test_reset;
        test_single_read;
        test_burst_write;
        test_alternate;
        test_watchdog;
        test_last_beat_timeout;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
